// File: rtl/paridad_serial.sv
// Serial frame receiver: N data bits LSB first plus one parity bit, checked
// against even or odd parity with a running XOR accumulator.
module paridad_serial #(
    parameter int N             = 8,
    parameter bit PARIDAD_IMPAR = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic         bit_in,
    input  logic         valido,
    output logic [N-1:0] datos,
    output logic         listo,
    output logic         error_par,
    output logic         ocupado,
    output logic [1:0]   estado
);

    // Handshake: bit_in is consumed on every cycle valido is high while a frame
    // is open; there is no back-pressure, so the source never waits on us.
    // inicio always wins over valido in the same cycle.

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        RECIBE  = 2'd1,
        PARIDAD = 2'd2
    } estado_t;

    estado_t       st, st_n;
    logic [N-1:0]  sr, sr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          acc, acc_n;
    logic [N-1:0]  datos_n;
    logic          listo_n;
    logic          error_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ESPERA;
            sr        <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            datos     <= '0;
            listo     <= 1'b0;
            error_par <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            st        <= st_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            datos     <= datos_n;
            listo     <= listo_n;
            error_par <= error_n;
            ocupado   <= (st_n != ESPERA);
        end
    end

    always_comb begin
        st_n    = st;
        sr_n    = sr;
        cnt_n   = cnt;
        acc_n   = acc;
        datos_n = datos;
        listo_n = 1'b0;
        error_n = error_par;

        // A start strobe reinitialises from any state; a bit in that cycle is dropped.
        if (inicio) begin
            st_n  = RECIBE;
            sr_n  = '0;
            cnt_n = '0;
            acc_n = PARIDAD_IMPAR;
        end else begin
            case (st)
                ESPERA: begin
                    st_n = ESPERA;
                end
                RECIBE: begin
                    if (valido) begin
                        sr_n[cnt] = bit_in;
                        acc_n     = acc ^ bit_in;
                        if (cnt == ULTIMO) begin
                            cnt_n = '0;
                            st_n  = PARIDAD;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                PARIDAD: begin
                    if (valido) begin
                        datos_n = sr;
                        error_n = acc ^ bit_in;
                        listo_n = 1'b1;
                        st_n    = ESPERA;
                    end
                end
                default: begin
                    st_n = ESPERA;
                end
            endcase
        end
    end

    assign estado = st;

endmodule

// File: tb/tb_paridad_serial.sv
// Bench for paridad_serial: even and odd parity instances share one stimulus
// stream and are compared every cycle against a queue-based frame model.
module tb_paridad_serial;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic inicio = 1'b0;
    logic bit_in = 1'b0;
    logic valido = 1'b0;

    logic [N-1:0] datos_e, datos_o;
    logic listo_e, listo_o, error_e, error_o, ocupado_e, ocupado_o;
    logic [1:0] estado_e, estado_o;

    paridad_serial #(.N(N), .PARIDAD_IMPAR(1'b0)) dut_par (
        .clk(clk), .rst(rst), .inicio(inicio), .bit_in(bit_in), .valido(valido),
        .datos(datos_e), .listo(listo_e), .error_par(error_e), .ocupado(ocupado_e),
        .estado(estado_e)
    );

    paridad_serial #(.N(N), .PARIDAD_IMPAR(1'b1)) dut_impar (
        .clk(clk), .rst(rst), .inicio(inicio), .bit_in(bit_in), .valido(valido),
        .datos(datos_o), .listo(listo_o), .error_par(error_o), .ocupado(ocupado_o),
        .estado(estado_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame model: collect accepted bits in a queue, decide when N+1 have arrived.
    logic         bits_q[$];
    logic         m_activo = 1'b0;
    logic [N-1:0] m_datos = '0;
    logic         m_err_e = 1'b0;
    logic         m_err_o = 1'b0;
    logic         m_listo = 1'b0;

    int edge_n = 0;
    int listo_e_cnt = 0;
    int listo_o_cnt = 0;
    int listo_e_edge = 0;
    int listo_o_edges[$];
    logic listo_o_errs[$];

    task automatic model_step(input logic r, input logic i, input logic v, input logic b);
        int unos;
        int palabra;
        if (r) begin
            m_activo = 1'b0;
            bits_q.delete();
            m_datos = '0;
            m_err_e = 1'b0;
            m_err_o = 1'b0;
            m_listo = 1'b0;
        end else begin
            m_listo = 1'b0;
            if (i) begin
                m_activo = 1'b1;
                bits_q.delete();
            end else if (m_activo && v) begin
                bits_q.push_back(b);
                if (bits_q.size() == N + 1) begin
                    unos = 0;
                    palabra = 0;
                    for (int k = 0; k < N; k++) palabra += int'(bits_q[k]) * (1 << k);
                    for (int k = 0; k <= N; k++) unos += int'(bits_q[k]);
                    m_datos  = palabra[N-1:0];
                    m_err_e  = (unos % 2) != 0;
                    m_err_o  = (unos % 2) != 1;
                    m_listo  = 1'b1;
                    m_activo = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic i, input logic v, input logic b);
        rst = r;
        inicio = i;
        valido = v;
        bit_in = b;
        @(posedge clk);
        edge_n++;
        model_step(r, i, v, b);
        #1;
        check("listo_par", 32'(listo_e), 32'(m_listo));
        check("datos_par", 32'(datos_e), 32'(m_datos));
        check("error_par_par", 32'(error_e), 32'(m_err_e));
        check("ocupado_par", 32'(ocupado_e), 32'(m_activo));
        check("listo_impar", 32'(listo_o), 32'(m_listo));
        check("datos_impar", 32'(datos_o), 32'(m_datos));
        check("error_par_impar", 32'(error_o), 32'(m_err_o));
        check("ocupado_impar", 32'(ocupado_o), 32'(m_activo));
        if (listo_e) begin
            listo_e_cnt++;
            listo_e_edge = edge_n;
        end
        if (listo_o) begin
            listo_o_cnt++;
            listo_o_edges.push_back(edge_n);
            listo_o_errs.push_back(error_o);
        end
    endtask

    task automatic send_bits(input logic [N-1:0] d, input logic p, input int gmin, input int gmax);
        for (int k = 0; k <= N; k++) begin
            int gap;
            gap = (gmax > 0) ? int'($urandom_range(gmax, gmin)) : 0;
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
            step(1'b0, 1'b0, 1'b1, (k < N) ? d[k] : p);
        end
    endtask

    initial begin
        int base_cnt;
        int inicio_edge;
        int idx;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_listo", 32'(listo_e), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 1: reset mid-frame, then a stream with no inicio must be ignored
        base_cnt = listo_e_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_datos", 32'(datos_e), 32'd0);
        check("rst_mid_ocupado", 32'(ocupado_e), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_mid_no_listo", 32'(listo_e_cnt - base_cnt), 32'd0);

        // 2: 0xA5, even parity bit 0, continuous; inicio..parity spans 10 cycles
        base_cnt = listo_e_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        inicio_edge = edge_n;
        send_bits(8'hA5, 1'b0, 0, 0);
        check("t2_latency", 32'(listo_e_edge - inicio_edge + 1), 32'd10);
        check("t2_datos", 32'(datos_e), 32'hA5);
        check("t2_error", 32'(error_e), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_one_listo", 32'(listo_e_cnt - base_cnt), 32'd1);

        // 3: same frame with wrong parity bit
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'hA5, 1'b1, 0, 0);
        check("t3_datos", 32'(datos_e), 32'hA5);
        check("t3_error", 32'(error_e), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 4: gapped stream
        base_cnt = listo_e_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'h3C, 1'b0, 1, 5);
        check("t4_datos", 32'(datos_e), 32'h3C);
        check("t4_error", 32'(error_e), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_one_listo", 32'(listo_e_cnt - base_cnt), 32'd1);

        // 5: abort after 4 bits; the bit beside the second inicio is discarded
        base_cnt = listo_e_cnt;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        send_bits(8'hFF, 1'b0, 0, 0);
        check("t5_datos", 32'(datos_e), 32'hFF);
        check("t5_error", 32'(error_e), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_one_listo", 32'(listo_e_cnt - base_cnt), 32'd1);

        // 6: odd parity, back-to-back frames with inicio during listo
        idx = listo_o_edges.size();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'h00, 1'b1, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'h00, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_two_listo", 32'(listo_o_edges.size() - idx), 32'd2);
        if (listo_o_edges.size() - idx == 2) begin
            check("t6_spacing", 32'(listo_o_edges[idx+1] - listo_o_edges[idx]), 32'd10);
            check("t6_err_first", 32'(listo_o_errs[idx]), 32'd0);
            check("t6_err_second", 32'(listo_o_errs[idx+1]), 32'd1);
        end

        // Random traffic: sparse starts/resets, dense valid bits
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(29, 0) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
                 1'($urandom));
        end
        check("random_frames_seen", 32'(listo_e_cnt > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paridad_serial.md
# paridad_serial

- Serial frame receiver and parity checker, directly downstream of the XOR stage: consumes the bit stream on that stage's `x` output.
- Assembles `N` data bits, LSB first, followed by one parity bit.
- Checks even or odd parity with a running XOR accumulator.
- Presents the assembled word with a one-cycle completion pulse and a parity-error flag.

## Interface

Parameters:
- `N`, default 8: data bits per frame; legal range 2..16.
- `PARIDAD_IMPAR`, default 0: 0 = even parity (XOR of data and parity bit = 0), 1 = odd parity (XOR = 1).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `inicio`  in  1: start-of-frame strobe.
- `bit_in`  in  1: serial bit, driven by the XOR stage output `x`.
- `valido`  in  1: qualifies `bit_in` in the current cycle.
- `datos`  out  N: last completed frame's data word.
- `listo`  out  1: one-cycle pulse, frame complete.
- `error_par`  out  1: parity result of the last completed frame; 1 = mismatch.
- `ocupado`  out  1: high while a frame is in progress.

## Operation

- FSM states: ESPERA, RECIBE, PARIDAD.
- Internal registers:
  - shift register `sr[N-1:0]`;
  - bit counter `cnt` (width clog2(N), minimum 1);
  - accumulator `acc` (1 bit).
- Reset (`rst`=1 at a clock edge), wherever the FSM is:
  - state = ESPERA; `sr` = 0, `cnt` = 0, `acc` = 0;
  - `datos` = 0, `listo` = 0, `error_par` = 0, `ocupado` = 0.
  - `rst` has priority over every other input.
- ESPERA:
  - `valido` is ignored.
  - `inicio`=1: go to RECIBE with `cnt` = 0, `sr` = 0, `acc` = `PARIDAD_IMPAR`.
- RECIBE, each cycle with `valido`=1:
  - `sr[cnt]` = `bit_in`;
  - `acc` = `acc` ^ `bit_in`;
  - `cnt` = `cnt` + 1.
  - When the accepted bit has `cnt` = N-1: go to PARIDAD and clear `cnt`.
  - `valido`=0: hold everything; gaps of any length are legal.
- PARIDAD, on `valido`=1:
  - `datos` = `sr`;
  - `error_par` = `acc` ^ `bit_in`;
  - `listo` = 1 for the next cycle only;
  - go to ESPERA.
- `inicio`=1 in RECIBE or PARIDAD aborts the current frame:
  - reinitialise as on a start from ESPERA and stay in or return to RECIBE;
  - a `valido` bit in the same cycle is discarded;
  - the aborted frame produces no `listo`;
  - `datos` and `error_par` are unchanged.
- `inicio` and `valido` in the same cycle from ESPERA: the bit is discarded; the first data bit is taken on a later cycle.
- `datos` and `error_par` hold their value until the next completed frame. They are not cleared by `inicio`.
- `ocupado` = 1 exactly when the state is RECIBE or PARIDAD.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Latency: parity bit accepted at edge k → `listo`=1 in the cycle after edge k, with `datos`/`error_par` already updated. `listo` drops after edge k+1.
- `ocupado` goes high the cycle after the accepting `inicio` edge. It goes low in the same cycle `listo` rises.
- Minimum frame length: 1 `inicio` cycle + N+1 `valido` cycles = N+2 cycles (10 for N=8).
- Back-to-back frames: `inicio` is accepted in the cycle `listo` is high. No dead cycle is required.
- `cnt` never exceeds N-1. There is no wrap-around path outside the RECIBE→PARIDAD transition.

## Test plan

1. Reset mid-frame:
   - Stimulus: `inicio`, 3 valid bits, then `rst`=1 for 2 cycles; then `valido`=1 with `bit_in`=1 for 12 cycles, no `inicio`.
   - Required: all outputs 0 after the first reset edge; no `listo`, `ocupado`=0 throughout.
2. N=8, even parity, correct frame:
   - Stimulus: `inicio`, then bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), then parity 0, `valido` continuous.
   - Required: `listo` one cycle, `datos`=0xA5, `error_par`=0, total 10 cycles from `inicio` to `listo`.
3. Same frame with parity bit 1:
   - Required: `listo` one cycle, `datos`=0xA5, `error_par`=1.
4. Gapped stream:
   - Stimulus: 0x3C with parity 0, `valido` deasserted 1–5 random cycles between bits.
   - Required: single `listo`, `datos`=0x3C, `error_par`=0, `ocupado` high continuously until `listo`.
5. Abort:
   - Stimulus: `inicio`, 4 bits of 0x0F; `inicio` again with `valido`=1 and `bit_in`=0 in that cycle; then 0xFF with parity 0.
   - Required: exactly one `listo`, `datos`=0xFF, `error_par`=0.
6. Odd parity and back-to-back (`PARIDAD_IMPAR`=1):
   - Stimulus: frame 0x00 with parity 1; `inicio` in the cycle `listo` is high; then 0x00 with parity 0.
   - Required: first `listo` with `error_par`=0; second `listo` exactly 10 cycles later with `error_par`=1.
